leaf_user_rx_port: RTL and testbench

User-side receiver for one leaf-interface output port: consumes the `dout_leaf_interface2user_N` / `vld_interface2user_N` / `ack_user2interface_N` handshake driven by `leaf_interface` and presents the words to an HLS user kernel as a first-word-fall-through valid/ready stream. It sits inside the user kernel region in the `clk_user` domain, one instance per input port, with a small FIFO that absorbs kernel back-pressure. `ack_user2interface` is decoded from registered state only, so there is no combinational path from kernel ready back to the leaf interface.

---
 rtl/leaf_user_rx_port_if.sv | 30 +++
 rtl/leaf_user_rx_port.sv | 88 ++++++++
 tb/tb_leaf_user_rx_port.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/leaf_user_rx_port_if.sv
// Leaf-interface receive handshake plus the FWFT stream toward the user kernel.
// The receiver port uses the slave modport; whoever drives the leaf side and consumes the stream uses master.
interface leaf_user_rx_port_if #(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic                    vld_interface2user;
    logic                    ack_user2interface;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  dout_leaf_interface2user,
        input  vld_interface2user,
        output ack_user2interface,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output dout_leaf_interface2user,
        output vld_interface2user,
        input  ack_user2interface,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/leaf_user_rx_port.sv
// User-side receiver for one leaf-interface output port: small FWFT FIFO between the
// leaf vld/ack handshake and the kernel valid/ready stream, with a wrapping accepted-word counter.
module leaf_user_rx_port #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH        = 4,
    parameter int ADDR_BITS    = 2
) (
    input  logic                 clk_user,
    input  logic                 reset_n,
    leaf_user_rx_port_if.slave   bus,
    input  logic                 i_flush,
    output logic [31:0]          o_word_count
);
    localparam logic [ADDR_BITS:0] L_FULL  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] L_EMPTY = '0;

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS:0]      r_count;
    logic [ADDR_BITS-1:0]    r_wr_ptr;
    logic [ADDR_BITS-1:0]    r_rd_ptr;
    logic [31:0]             r_word_count;

    logic [ADDR_BITS:0]      w_count_next;
    logic [ADDR_BITS-1:0]    w_wr_ptr_next;
    logic [ADDR_BITS-1:0]    w_rd_ptr_next;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ack;
    logic                    w_valid;

    // Handshake flags come only from the registered count, so kernel ready never reaches ack.
    assign w_ack   = (r_count != L_FULL);
    assign w_valid = (r_count != L_EMPTY);
    assign w_push  = bus.vld_interface2user && w_ack;
    assign w_pop   = w_valid && bus.out_ready;

    assign bus.ack_user2interface = w_ack;
    assign bus.out_valid          = w_valid;
    assign bus.out_data           = r_mem[r_rd_ptr];
    assign o_word_count           = r_word_count;

    always_comb begin
        w_count_next  = r_count;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (i_flush) begin
            // Flush wins over any same-cycle push or pop; that pushed word is dropped.
            w_count_next  = '0;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word_count <= '0;
        end else begin
            r_count  <= w_count_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            if (w_push) begin
                r_word_count <= r_word_count + 32'd1;
            end
        end
    end

    // Storage carries no reset; a slot is only read after it has been written.
    always_ff @(posedge clk_user) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.dout_leaf_interface2user;
        end
    end
endmodule

// File: tb/tb_leaf_user_rx_port.sv
// Randomised self-checking bench for leaf_user_rx_port against a queue-based FIFO model.
module tb_leaf_user_rx_port;
    localparam int DEPTH = 4;

    logic        clk_user = 1'b0;
    logic        reset_n  = 1'b0;
    logic        flush    = 1'b0;
    logic [31:0] word_count;

    logic [31:0] mq[$];
    logic [31:0] m_wc;
    int          n_checks = 0;
    int          n_errors = 0;

    leaf_user_rx_port_if #(.PAYLOAD_BITS(32)) bus ();

    leaf_user_rx_port #(.PAYLOAD_BITS(32), .DEPTH(DEPTH), .ADDR_BITS(2)) dut (
        .clk_user     (clk_user),
        .reset_n      (reset_n),
        .bus          (bus),
        .i_flush      (flush),
        .o_word_count (word_count)
    );

    always #5 clk_user = ~clk_user;

    // One clock of stimulus; the model advances from what the FIFO rules allow, not from the DUT.
    task automatic drive_cycle(input logic vld, input logic [31:0] d, input logic rdy, input logic fl,
                               output logic pushed, output logic popped);
        bus.vld_interface2user       = vld;
        bus.dout_leaf_interface2user = d;
        bus.out_ready                = rdy;
        flush                        = fl;
        pushed = vld && (mq.size() < DEPTH);
        popped = rdy && (mq.size() > 0);
        @(posedge clk_user);
        if (pushed) m_wc = m_wc + 32'd1;
        if (fl) begin
            mq.delete();
        end else begin
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back(d);
        end
        @(negedge clk_user);
        bus.vld_interface2user = 1'b0;
        bus.out_ready          = 1'b0;
        flush                  = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        mq.delete();
        m_wc = '0;
        repeat (2) @(negedge clk_user);
        reset_n = 1'b1;
        @(negedge clk_user);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mq.delete();
        m_wc = '0;
        repeat (2) @(negedge clk_user);
        n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL reset_ack: got %b expected 1", bus.ack_user2interface); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (word_count !== 32'd0) begin n_errors++; $display("FAIL reset_wc: got %0d expected 0", word_count); end
        reset_n = 1'b1;
        @(negedge clk_user);
        n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL post_reset_ack: got %b expected 1", bus.ack_user2interface); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_valid: got %b expected 0", bus.out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic p, q;
        int   pops = 0;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL basic_ack cyc%0d: got %b expected 1", i, bus.ack_user2interface); end
            n_checks++; if (bus.out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL basic_valid cyc%0d: got %b expected %b", i, bus.out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if (bus.out_data !== mq[0]) begin n_errors++; $display("FAIL basic_data cyc%0d: got %h expected %h", i, bus.out_data, mq[0]); end
            end
            if (bus.out_valid === 1'b1) pops++;
            drive_cycle(1'(i < 4), 32'hA000_0001 + 32'(i), 1'b1, 1'b0, p, q);
        end
        n_checks++; if (pops != 4) begin n_errors++; $display("FAIL basic_pops: got %0d expected 4", pops); end
        n_checks++; if (word_count !== 32'd4) begin n_errors++; $display("FAIL basic_wc: got %0d expected 4", word_count); end
        $display("test_basic done: %0d words out", pops);
    endtask

    task automatic test_full();
        logic        p, q;
        int          acc = 0;
        logic [31:0] pl  = 32'hB000_0000;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (bus.ack_user2interface !== (mq.size() != DEPTH)) begin n_errors++; $display("FAIL full_ack cyc%0d: got %b expected %b", i, bus.ack_user2interface, mq.size() != DEPTH); end
            if (bus.ack_user2interface === 1'b1) acc++;
            drive_cycle(1'b1, pl, 1'b0, 1'b0, p, q);
            pl = pl + 32'd1;
        end
        n_checks++; if (acc != DEPTH) begin n_errors++; $display("FAIL full_accepted: got %0d expected %0d", acc, DEPTH); end
        n_checks++; if (bus.out_data !== 32'hB000_0000) begin n_errors++; $display("FAIL full_head: got %h expected b0000000", bus.out_data); end
        drive_cycle(1'b1, pl, 1'b1, 1'b0, p, q);
        pl = pl + 32'd1;
        n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL full_ack_after_pop: got %b expected 1", bus.ack_user2interface); end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.ack_user2interface !== (mq.size() != DEPTH)) begin n_errors++; $display("FAIL refill_ack cyc%0d: got %b expected %b", i, bus.ack_user2interface, mq.size() != DEPTH); end
            if (bus.ack_user2interface === 1'b1) acc++;
            drive_cycle(1'b1, pl, 1'b0, 1'b0, p, q);
            pl = pl + 32'd1;
        end
        n_checks++; if (acc != 1) begin n_errors++; $display("FAIL refill_accepted: got %0d expected 1", acc); end
        for (int i = 0; i < 8 && mq.size() > 0; i++) begin
            n_checks++; if (bus.out_data !== mq[0]) begin n_errors++; $display("FAIL full_drain_data: got %h expected %h", bus.out_data, mq[0]); end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, p, q);
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL full_drained_valid: got %b expected 0", bus.out_valid); end
        $display("test_full done");
    endtask

    task automatic test_stream();
        logic p, q;
        apply_reset();
        for (int i = 0; i <= 1000; i++) begin
            n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL stream_ack cyc%0d: got %b expected 1", i, bus.ack_user2interface); end
            if (i > 0) begin
                n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_bubble cyc%0d: got %b expected 1", i, bus.out_valid); end
            end
            if (mq.size() != 0) begin
                n_checks++; if (bus.out_data !== mq[0]) begin n_errors++; $display("FAIL stream_data cyc%0d: got %h expected %h", i, bus.out_data, mq[0]); end
            end
            drive_cycle(1'(i < 1000), $urandom, 1'b1, 1'b0, p, q);
        end
        n_checks++; if (word_count !== 32'd1000) begin n_errors++; $display("FAIL stream_wc: got %0d expected 1000", word_count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_end_valid: got %b expected 0", bus.out_valid); end
        $display("test_stream done: 1000 words");
    endtask

    task automatic test_flush();
        logic p, q;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, p, q);
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, p, q);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL flush_ack: got %b expected 1", bus.ack_user2interface); end
        n_checks++; if (word_count !== m_wc) begin n_errors++; $display("FAIL flush_wc: got %0d expected %0d", word_count, m_wc); end
        for (int i = 0; i < 4; i++) begin
            if (mq.size() != 0) begin
                n_checks++; if (bus.out_data !== mq[0]) begin n_errors++; $display("FAIL flush_after_data: got %h expected %h", bus.out_data, mq[0]); end
            end
            drive_cycle(1'(i < 2), 32'hF000_0001 + 32'(i), 1'b1, 1'b0, p, q);
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_end_valid: got %b expected 0", bus.out_valid); end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        logic p, q;
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, 32'h0000_0011 * 32'(i + 1), 1'b0, 1'b0, p, q);
        bus.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        mq.delete();
        m_wc = '0;
        n_checks++; if (bus.ack_user2interface !== 1'b1) begin n_errors++; $display("FAIL midreset_ack: got %b expected 1", bus.ack_user2interface); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (word_count !== 32'd0) begin n_errors++; $display("FAIL midreset_wc: got %0d expected 0", word_count); end
        @(negedge clk_user);
        bus.out_ready = 1'b0;
        reset_n = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_stale: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL midreset_valid cyc%0d: got %b expected %b", i, bus.out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if (bus.out_data !== mq[0]) begin n_errors++; $display("FAIL midreset_data cyc%0d: got %h expected %h", i, bus.out_data, mq[0]); end
            end
            drive_cycle(1'(i < 2), 32'h5 + 32'(i), 1'(i % 2), 1'b0, p, q);
        end
        n_checks++; if (word_count !== 32'd2) begin n_errors++; $display("FAIL midreset_wc_after: got %0d expected 2", word_count); end
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap_count();
        logic p, q;
        force dut.r_word_count = 32'hFFFF_FFFF;
        @(posedge clk_user);
        @(negedge clk_user);
        release dut.r_word_count;
        m_wc = 32'hFFFF_FFFF;
        n_checks++; if (word_count !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_preload: got %h expected ffffffff", word_count); end
        drive_cycle(1'b1, 32'h7, 1'b0, 1'b0, p, q);
        n_checks++; if (word_count !== m_wc) begin n_errors++; $display("FAIL wrap_wc: got %h expected %h", word_count, m_wc); end
        n_checks++; if (bus.out_data !== 32'h7) begin n_errors++; $display("FAIL wrap_data: got %h expected 00000007", bus.out_data); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, p, q);
        $display("test_wrap_count done");
    endtask

    initial begin
        bus.vld_interface2user       = 1'b0;
        bus.dout_leaf_interface2user = '0;
        bus.out_ready                = 1'b0;
        m_wc                         = '0;
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_flush();
        test_reset_mid();
        test_wrap_count();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
